// File: rtl/dro_reader.sv
// Caliper-style DRO frame receiver: synchronises the clock/data pins and waits for an inter-frame gap
// before capturing a timestamped frame, which it presents on a valid/ready interface.
// Optional define DRO_DECODE_EN adds the sign/magnitude position and unit-flag decode.
module dro_reader #(
  parameter int unsigned NBITS       = 24,
  parameter int unsigned GAP_CYCLES  = 4800,
  parameter int unsigned TIMEOUT_CYC = 2400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      systime,
  input  logic             dro_clk,
  input  logic             dro_do,
  output logic [NBITS-1:0] frame_data,
  output logic [31:0]      frame_time,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             overrun,
  output logic [7:0]       timeout_cnt,
  input  logic             err_clr,
  output logic [20:0]      pos,
  output logic             inch
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYC) ? GAP_CYCLES : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RECV  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pin synchronisers; clk_prev_q is the previous synchronised clock for edge detection
  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic do_meta_q, do_meta_d;
  logic do_sync_q, do_sync_d;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [31:0]        start_time_q, start_time_d;

  logic [NBITS-1:0]   frame_data_q, frame_data_d;
  logic [31:0]        frame_time_q, frame_time_d;
  logic               frame_valid_q, frame_valid_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         timeout_cnt_q, timeout_cnt_d;

  logic               fall_c;
  logic               load_c;
  logic               timeout_c;
  logic               xfer_c;

  always_comb begin
    clk_meta_d = dro_clk;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    do_meta_d  = dro_do;
    do_sync_d  = do_meta_q;
  end

  assign fall_c = clk_prev_q & ~clk_sync_q;

  // Frame capture FSM; one counter serves as gap counter in IDLE and idle timer in RECV
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    start_time_d = start_time_q;
    load_c       = 1'b0;
    timeout_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q == CNT_W'(GAP_CYCLES)) begin
          state_d = ST_ARMED;
        end else if (clk_sync_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_ARMED: begin
        if (fall_c) begin
          state_d      = ST_RECV;
          start_time_d = systime;
          shift_d      = {do_sync_q, shift_q[NBITS-1:1]};
          bitcnt_d     = BIT_W'(1);
          cnt_d        = '0;
        end
      end
      ST_RECV: begin
        if (fall_c) begin
          shift_d  = {do_sync_q, shift_q[NBITS-1:1]};
          bitcnt_d = bitcnt_q + BIT_W'(1);
          cnt_d    = '0;
          if (bitcnt_q + BIT_W'(1) == BIT_W'(NBITS)) begin
            state_d = ST_DONE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        load_c  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers: a new load overwrites; set events win over err_clr
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_time_d  = frame_time_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    timeout_cnt_d = timeout_cnt_q;
    xfer_c        = frame_valid_q & frame_ready;
    if (xfer_c) begin
      frame_valid_d = 1'b0;
    end
    if (load_c) begin
      frame_valid_d = 1'b1;
      frame_data_d  = shift_q;
      frame_time_d  = start_time_q;
    end
    if (load_c && frame_valid_q && !frame_ready) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end
    if (timeout_c) begin
      if (timeout_cnt_q != 8'hFF) begin
        timeout_cnt_d = timeout_cnt_q + 8'd1;
      end
    end else if (err_clr) begin
      timeout_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      clk_prev_q    <= 1'b1;
      do_meta_q     <= 1'b0;
      do_sync_q     <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      start_time_q  <= '0;
      frame_data_q  <= '0;
      frame_time_q  <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_cnt_q <= 8'd0;
    end else begin
      clk_meta_q    <= clk_meta_d;
      clk_sync_q    <= clk_sync_d;
      clk_prev_q    <= clk_prev_d;
      do_meta_q     <= do_meta_d;
      do_sync_q     <= do_sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      start_time_q  <= start_time_d;
      frame_data_q  <= frame_data_d;
      frame_time_q  <= frame_time_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_time  = frame_time_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign timeout_cnt = timeout_cnt_q;

`ifdef DRO_DECODE_EN
  // Sign-magnitude to two's complement, captured with the frame
  logic [20:0] pos_q, pos_d;
  logic        inch_q, inch_d;
  logic [20:0] mag_c;

  always_comb begin
    mag_c  = {1'b0, shift_q[19:0]};
    pos_d  = pos_q;
    inch_d = inch_q;
    if (load_c) begin
      pos_d  = shift_q[20] ? (21'd0 - mag_c) : mag_c;
      inch_d = shift_q[23];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      inch_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      inch_q <= inch_d;
    end
  end

  assign pos  = pos_q;
  assign inch = inch_q;
`else
  assign pos  = '0;
  assign inch = 1'b0;
`endif

endmodule
